key_cfg_ctrl: RTL

Configuration controller between the debounced push-button front end and the audio processing datapath. It collects single-cycle press pulses from four `key` instances and holds each as a pending request. Requests are served one at a time by a round-robin arbiter, and each served request updates a volume/mode/mute shadow register set. Every update is delivered to the datapath as one configuration word over a valid/ready handshake.

---
 rtl/key_cfg_ctrl_pkg.sv | 22 ++
 rtl/key_cfg_ctrl_rr_arb4.sv | 32 +++
 rtl/key_cfg_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/key_cfg_ctrl_pkg.sv
// Shared constants for the key configuration controller: key indices, FSM encoding, mode count.
// No logic of its own; imported by key_cfg_ctrl and rr_arb4.
package key_pkg;

    localparam logic [1:0] KEY_VUP  = 2'd0;
    localparam logic [1:0] KEY_VDN  = 2'd1;
    localparam logic [1:0] KEY_MODE = 2'd2;
    localparam logic [1:0] KEY_MUTE = 2'd3;

    localparam int KEY_NUM  = 4;
    localparam int MODE_NUM = 4;
    localparam logic [1:0] MODE_MAX = 2'(MODE_NUM - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    function automatic logic [1:0] mode_next(input logic [1:0] m);
        return (m == MODE_MAX) ? 2'd0 : m + 2'd1;
    endfunction

endpackage

// File: rtl/key_cfg_ctrl_rr_arb4.sv
// Combinational round-robin pick over four requests, searching upward from ptr_i (mod 4).
// Zero latency; gnt_o is all-zero when no request is present.
module rr_arb4
    import key_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o
);

    logic [1:0] cand;
    logic [1:0] sel;
    logic       found;

    always_comb begin
        cand  = ptr_i;
        sel   = ptr_i;
        found = 1'b0;
        for (int k = 0; k < KEY_NUM; k++) begin
            cand = ptr_i + 2'(k);
            if (!found && req_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign gnt_idx_o = sel;
    assign gnt_o     = found ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/key_cfg_ctrl.sv
// Collects key press pulses, serves them round-robin into vol/mode/mute shadow state, and offers
// each update as one config word; a stalled word (cfg_ready low) holds the FSM in SEND while presses keep queueing.
module key_cfg_ctrl
    import key_pkg::*;
#(
    parameter int VOL_W   = 4,
    parameter int VOL_DEF = 8,
    parameter int DBL_WIN = 2_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_on,
    input  logic             cfg_ready,
    output logic             cfg_valid,
    output logic [VOL_W-1:0] cfg_vol,
    output logic [1:0]       cfg_mode,
    output logic             cfg_mute,
    output logic [3:0]       pend,
    output logic             ovf
);

    localparam int WIN_W = $clog2(DBL_WIN + 1);
    localparam logic [VOL_W-1:0] VOL_MAX   = {VOL_W{1'b1}};
    localparam logic [VOL_W-1:0] VOL_RST   = VOL_W'(VOL_DEF);
    localparam logic [WIN_W-1:0] WIN_LOAD  = WIN_W'(DBL_WIN);

    logic [1:0]       state_q, state_d;
    logic [3:0]       pend_q,  pend_d;
    logic [1:0]       rr_q,    rr_d;
    logic [VOL_W-1:0] vol_q,   vol_d;
    logic [1:0]       mode_q,  mode_d;
    logic             mute_q,  mute_d;
    logic [WIN_W-1:0] win_q,   win_d;
    logic             ovf_q,   ovf_d;

    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       grant_en;
    logic [3:0] clr;

    rr_arb4 u_arb (
        .req_i     (pend_q),
        .ptr_i     (rr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign grant_en = (state_q == ST_IDLE) && (pend_q != 4'b0000);
    assign clr      = grant_en ? gnt : 4'b0000;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        vol_d   = vol_q;
        mode_d  = mode_q;
        mute_d  = mute_q;
        win_d   = (win_q != '0) ? win_q - WIN_W'(1) : '0;
        // A press on a bit being granted this cycle re-arms it; only a press on a bit that stays set is lost.
        pend_d  = (pend_q & ~clr) | key_on;
        ovf_d   = ovf_q | (|(key_on & pend_q & ~clr));

        case (state_q)
            ST_INIT: state_d = ST_SEND;
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_SEND;
                    rr_d    = gnt_idx + 2'd1;
                    case (gnt_idx)
                        KEY_VUP: if (vol_q != VOL_MAX) vol_d = vol_q + VOL_W'(1);
                        KEY_VDN: if (vol_q != '0)      vol_d = vol_q - VOL_W'(1);
                        KEY_MODE: begin
                            // Second mode press inside the window jumps back to mode 0.
                            if (win_q != '0) begin
                                mode_d = 2'd0;
                                win_d  = '0;
                            end else begin
                                mode_d = mode_next(mode_q);
                                win_d  = WIN_LOAD;
                            end
                        end
                        KEY_MUTE: mute_d = ~mute_q;
                        default:  ;
                    endcase
                end
            end
            ST_SEND: if (cfg_ready) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            pend_q  <= 4'b0000;
            rr_q    <= 2'd0;
            vol_q   <= VOL_RST;
            mode_q  <= 2'd0;
            mute_q  <= 1'b0;
            win_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            vol_q   <= vol_d;
            mode_q  <= mode_d;
            mute_q  <= mute_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cfg_valid = (state_q == ST_SEND);
    assign cfg_vol   = vol_q;
    assign cfg_mode  = mode_q;
    assign cfg_mute  = mute_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;

endmodule
